// File: rtl/digit_entry_display_pkg.sv
// Shared types and seven-segment helpers for the keypad entry / display block.
// Segment patterns are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    function automatic logic [6:0] hex7(input digit_t d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digit_entry_display_scan.sv
// Free-running refresh divider and digit-slot index for the multiplexed display.
// idx advances once every REFRESH_DIV clocks and wraps after DIGITS slots.
module seg7_scan #(
    parameter  int DIGITS      = 4,
    parameter  int REFRESH_DIV = 100000,
    localparam int IW          = $clog2(DIGITS),
    localparam int DW          = $clog2(REFRESH_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx
);

    logic [DW-1:0] div_cnt;
    logic          slot_end;

    assign slot_end = (div_cnt == DW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/digit_entry_display.sv
// Keypad digit entry with backspace/commit, driving a multiplexed common-anode
// seven-segment display with leading-digit blanking and a latched committed word.
module digit_entry_display
    import seg7_pkg::*;
#(
    parameter  int DIGITS      = 4,
    parameter  int REFRESH_DIV = 100000,
    localparam int CW          = $clog2(DIGITS + 1),
    localparam int IW          = $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                del,
    input  logic                commit,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic [4*DIGITS-1:0] led,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                overflow,
    output logic                commit_done
);

    digit_t                entry_buf [DIGITS];
    digit_t                buf_next  [DIGITS];
    logic [CW-1:0]         count_next;
    logic                  overflow_next;
    logic                  commit_pend;
    logic [4*DIGITS-1:0]   led_next;
    logic [IW-1:0]         idx;
    logic [DIGITS-1:0]     an_next;
    logic [6:0]            seg_next;

    seg7_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (idx)
    );

    assign full = (count == CW'(DIGITS));

    // Priority commit > del > key; a dropped lower-priority event never flags overflow.
    always_comb begin
        buf_next      = entry_buf;
        count_next    = count;
        overflow_next = 1'b0;
        if (commit) begin
            for (int i = 0; i < DIGITS; i++) buf_next[i] = '0;
            count_next = '0;
        end else if (del) begin
            if (count != '0) begin
                for (int i = 0; i < DIGITS - 1; i++) buf_next[i] = entry_buf[i + 1];
                buf_next[DIGITS-1] = '0;
                count_next         = count - CW'(1);
            end
        end else if (key_valid) begin
            if (full) begin
                overflow_next = 1'b1;
            end else begin
                for (int i = 1; i < DIGITS; i++) buf_next[i] = entry_buf[i - 1];
                buf_next[0] = key_code;
                count_next  = count + CW'(1);
            end
        end
    end

    always_comb begin
        led_next = '0;
        for (int i = 0; i < DIGITS; i++) led_next[4*i +: 4] = entry_buf[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) entry_buf[i] <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            commit_pend <= 1'b0;
            commit_done <= 1'b0;
            led         <= '0;
        end else begin
            entry_buf   <= buf_next;
            count       <= count_next;
            overflow    <= overflow_next;
            commit_pend <= commit;
            commit_done <= commit_pend;
            if (commit) led <= led_next;
        end
    end

    // Positions at or above count are leading blanks: anode off, all segments dark.
    always_comb begin
        an_next  = AN_OFF[DIGITS-1:0];
        seg_next = SEG_BLANK;
        if (CW'(idx) < count) begin
            an_next[idx] = 1'b0;
            seg_next     = hex7(entry_buf[idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= AN_OFF[DIGITS-1:0];
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: doc/digit_entry_display.md
# digit_entry_display

Parametrised keypad-entry and multiplexed seven-segment display block for the numberle front end. It accepts decoded, debounced key events, builds a right-aligned entry of up to DIGITS hex digits with backspace and commit, and drives the active-low anode and cathode lines of a DIGITS-wide common-anode display. It sits between the keypad decoder/debouncers and the board pins. It also adds leading-digit blanking, delete, an overflow flag and a latched committed word.

## Interface
- DIGITS, 4: number of display digits and entry depth; legal range 2–8.
- REFRESH_DIV, 100000: clk cycles per digit slot; at 100 MHz this gives 1 kHz per digit; legal range ≥2.
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- key_valid  input  1  one-cycle pulse; key_code is valid.
- key_code  input  4  hex value of the pressed key, 0x0–0xF.
- del  input  1  one-cycle pulse from the debounced left button; removes the newest digit.
- commit  input  1  one-cycle pulse from the debounced right button; latches the entry.
- an  output  DIGITS  anode enables, active-low; an[0] is the rightmost digit.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- led  output  4*DIGITS  last committed word; the oldest digit is in the MSBs.
- count  output  $clog2(DIGITS+1)  number of digits currently entered.
- full  output  1  high when count == DIGITS.
- overflow  output  1  one-cycle pulse when key_valid arrives while full.
- commit_done  output  1  one-cycle pulse, one cycle after an accepted commit.

## Operation
- **Entry buffer:** DIGITS × 4-bit registers plus count.
- **Key accepted** (key_valid and not full): buf shifts left by one digit, buf[0] = key_code, count+1.
- **Key while full:** buffer is unchanged and overflow pulses.
- **del with count > 0:** buf shifts right, buf[DIGITS-1] = 0, count−1. del with count == 0 is ignored.
- **commit:**
  - led = packed buf, where digit i occupies bits [4i+3:4i].
  - buf and count clear.
  - commit_done pulses on the next cycle.
  - commit with count == 0 is legal: led becomes 0 and commit_done still pulses.
- **Same-cycle priority:** commit > del > key_valid. The lower-priority event is dropped, with no overflow pulse and no queuing.
- **Display scan:**
  - The divider counts 0..REFRESH_DIV−1. On wrap, digit index idx advances 0→DIGITS−1→0.
  - The anode for idx is driven low; all other anodes are high.
  - If idx ≥ count, that position is blank: the anode stays high and seg = 7'h7F.
  - When count == 0, every position is blank.
  - Otherwise seg = hex7(buf[idx]).
- **Hex encoding:** 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.

## Timing
- **Reset values:** an = all ones, seg = 7'h7F, led = 0, count = 0, full = 0, overflow = 0, commit_done = 0, divider = 0, idx = 0, buf = 0.
- **Event latency:** an event sampled at edge N updates buf, count and full at edge N. overflow is registered and high during cycle N+1. commit_done is high during cycle N+2 relative to the commit sample.
- **Display outputs:** an and seg are registered from (idx, buf, count). Each changes one cycle after idx or buf changes, with no glitch between digits.
- **Divider:** free-running and unaffected by entry events. idx increments exactly every REFRESH_DIV cycles.
- **Reset mid-operation:** rst_n low on any edge forces all reset values on that edge. Pending pulses are lost and led clears.

## Structure
- **Package seg7_pkg:**
  - function hex7(logic [3:0]) → logic [6:0], using the table above.
  - constants SEG_BLANK = 7'h7F and AN_OFF.
  - typedef digit_t = logic [3:0].
- **Sub-module seg7_scan (DIGITS, REFRESH_DIV):** divider plus idx counter, with output idx. All other logic stays in digit_entry_display.

## Test plan
- **Reset and blanking:** reset, then run 3×DIGITS×REFRESH_DIV cycles (sim REFRESH_DIV=4, DIGITS=4) → an stays 4'b1111, seg = 7'h7F, led = 0, count = 0.
- **Entry and scan:** keys 1,2,3,4 → count = 4, full = 1. During slot idx=0, an = 4'b1110, seg = 7'h19. During idx=3, an = 4'b0111, seg = 7'h79.
- **Overflow:** 5th key 0xA while full → overflow high for exactly one cycle, buffer unchanged. del, then key 0xA → digit 0 shows 7'h08, count = 4.
- **Commit:** after entry 1,2,3,4, pulse commit → led = 16'h1234, count = 0 on the next cycle, commit_done one cycle later, display fully blank.
- **Same-cycle events:** commit + key_valid in one cycle → key dropped. del + key_valid → only del takes effect. del at count 0 → no change.
- **Reset mid-entry:** rst_n low during partial entry with led = 16'h1234 → all outputs return to reset values on that edge.
